sar_search5: RTL and testbench

SAR_SEARCH5 -- requirements
Module: sar_search5

---
 rtl/sar_pkg.sv | 28 ++
 rtl/sar_search5.sv | 142 ++++++++++++++
 tb/tb_sar_search5.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared types and constants for the sar_search5 successive-
//                approximation search controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

    // Default width of the trial value, result and bit index range
    localparam int c_sar_width_default = 5;

    // Search controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } sar_state_t;

    // A comparator verdict is only meaningful when exactly one flag is set
    function automatic logic sar_onehot3(input logic a, input logic b, input logic c);
        return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sar_search5.sv
// ============================================================================
//  Module      : sar_search5
//  Description : Successive-approximation search controller. Drives a trial
//                value into an external magnitude comparator and resolves one
//                bit per clock, MSB first, until the target is found.
//                Optional macro SAR_EARLY_EXIT_EN: finish as soon as the
//                comparator reports equality instead of always taking WIDTH
//                decisions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search5
    import sar_pkg::*;
#(
    parameter int WIDTH = c_sar_width_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int               IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_lsb     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_msb     = c_lsb << (WIDTH - 1);
    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_idx_lo  = '0;

    sar_state_t       r_state;
    sar_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_trial;
    logic [WIDTH-1:0] w_trial_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_decided;
    logic             w_valid;
    logic             w_early;

    // Bit under test, the trial after applying this cycle's verdict, and
    // verdict validity
    always_comb begin
        w_mask    = c_lsb << r_idx;
        w_decided = cmp_gt ? (r_trial & ~w_mask) : r_trial;
        w_valid   = sar_onehot3(cmp_gt, cmp_eq, cmp_lt);
`ifdef SAR_EARLY_EXIT_EN
        w_early   = cmp_eq;
`else
        w_early   = 1'b0;
`endif
    end

    // State register; reset drops straight back to IDLE even mid-search
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath next values and status outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_result_nxt = r_result;
        w_idx_nxt    = r_idx;
        w_err_nxt    = r_err;
        busy         = (r_state == TRY);
        done         = (r_state == DONE);

        case (r_state)
            IDLE, DONE: begin
                // DONE accepts a new start exactly like IDLE
                if (start) begin
                    w_trial_nxt = c_msb;
                    w_idx_nxt   = c_idx_top;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = TRY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            TRY: begin
                if (!w_valid) begin
                    // Ambiguous comparator: abandon the search with a flagged zero
                    w_result_nxt = '0;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = DONE;
                end else if (w_early || (r_idx == c_idx_lo)) begin
                    // On equality w_decided equals the current trial
                    w_trial_nxt  = w_decided;
                    w_result_nxt = w_decided;
                    w_state_nxt  = DONE;
                end else begin
                    // Keep/clear this bit, then tentatively set the next one down
                    w_trial_nxt  = w_decided | (w_mask >> 1);
                    w_idx_nxt    = r_idx - c_idx_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: trial, result, bit index and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trial  <= '0;
            r_result <= '0;
            r_idx    <= c_idx_top;
            r_err    <= 1'b0;
        end else begin
            r_trial  <= w_trial_nxt;
            r_result <= w_result_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign trial  = r_trial;
    assign result = r_result;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_search5.sv
// ============================================================================
//  Module      : tb_sar_search5
//  Description : Directed self-checking bench for sar_search5 paired with a
//                behavioural magnitude comparator whose second operand is
//                the target. Honours SAR_EARLY_EXIT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_search5;
    import sar_pkg::*;

    localparam int W = c_sar_width_default;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         force_bad = 1'b0;
    logic [W-1:0] target    = '0;
    logic         cmp_gt;
    logic         cmp_eq;
    logic         cmp_lt;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: expected trial sequence, {err,result} and decision count
    logic [W-1:0] sb_trial[$];
    logic [W:0]   sb_out[$];
    int           sb_lat[$];

    // Comparator model; force_bad makes the verdict non-one-hot (gt and lt)
    assign cmp_gt = force_bad | (trial > target);
    assign cmp_lt = force_bad | (trial < target);
    assign cmp_eq = ~force_bad & (trial == target);

    sar_search5 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_trials(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                               input logic [W-1:0] d, input logic [W-1:0] e);
        sb_trial.push_back(a);
        sb_trial.push_back(b);
        sb_trial.push_back(c);
        sb_trial.push_back(d);
        sb_trial.push_back(e);
    endtask

    // Launch a search and follow it to its done cycle (returns in that cycle).
    // bad_at / restart_at: TRY cycle index at which to corrupt the verdict /
    // pulse start again (-1 = never).
    task automatic run(input string tag, input int bad_at, input int restart_at);
        int         cyc;
        logic [W:0] eo;
        int         el;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        check({tag, " err cleared at start"}, 32'(err), 32'd0);
        while (done !== 1'b1 && cyc < 2 * W) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            if (sb_trial.size() > 0) begin
                check({tag, " trial"}, 32'(trial), 32'(sb_trial.pop_front()));
            end
            force_bad = (cyc == bad_at);
            start     = (cyc == restart_at);
            tick();
            force_bad = 1'b0;
            start     = 1'b0;
            cyc++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy low in done"}, 32'(busy), 32'd0);
        eo = (sb_out.size() > 0) ? sb_out.pop_front() : '1;
        el = (sb_lat.size() > 0) ? sb_lat.pop_front() : -1;
        check({tag, " result"}, 32'(result), 32'(eo[W-1:0]));
        check({tag, " err"}, 32'(err), 32'(eo[W]));
        check({tag, " decisions"}, 32'(cyc), 32'(el));
        check({tag, " trials left"}, 32'(sb_trial.size()), 32'd0);
        sb_trial.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("reset trial",  32'(trial),  32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        check("reset err",    32'(err),    32'd0);
        rst_n = 1'b1;
        tick();

        // Comparator activity while idle must be ignored
        force_bad = 1'b1;
        tick();
        tick();
        force_bad = 1'b0;
        check("idle cmp err",  32'(err),  32'd0);
        check("idle cmp busy", 32'(busy), 32'd0);
        check("idle cmp done", 32'(done), 32'd0);

        // target = 0: every verdict is gt
        target = 5'd0;
        push_trials(5'd16, 5'd8, 5'd4, 5'd2, 5'd1);
        sb_out.push_back({1'b0, 5'd0});
        sb_lat.push_back(5);
        run("t0", -1, -1);
        tick();
        check("t0 done one cycle", 32'(done), 32'd0);

        // target = 31: every verdict lt until the final eq
        target = 5'd31;
        push_trials(5'd16, 5'd24, 5'd28, 5'd30, 5'd31);
        sb_out.push_back({1'b0, 5'd31});
        sb_lat.push_back(5);
        run("t31", -1, -1);
        tick();
        check("t31 result holds", 32'(result), 32'd31);
        check("t31 idle busy",    32'(busy),   32'd0);

        // target = 21, then a new start accepted directly in DONE with target 16
        target = 5'd21;
        push_trials(5'd16, 5'd24, 5'd20, 5'd22, 5'd21);
        sb_out.push_back({1'b0, 5'd21});
        sb_lat.push_back(5);
        run("t21", -1, -1);
        target = 5'd16;
`ifdef SAR_EARLY_EXIT_EN
        sb_trial.push_back(5'd16);
        sb_lat.push_back(1);
`else
        push_trials(5'd16, 5'd24, 5'd20, 5'd18, 5'd17);
        sb_lat.push_back(5);
`endif
        sb_out.push_back({1'b0, 5'd16});
        run("t16 b2b", -1, -1);
        tick();

        // Invalid verdict at the 2nd decision aborts with err
        target = 5'd21;
        sb_trial.push_back(5'd16);
        sb_trial.push_back(5'd24);
        sb_out.push_back({1'b1, 5'd0});
        sb_lat.push_back(2);
        run("bad", 1, -1);
        tick();
        check("bad err holds",    32'(err),    32'd1);
        check("bad result holds", 32'(result), 32'd0);

        // Start pulsed in the 3rd TRY cycle is ignored; err cleared by start
        target = 5'd9;
        push_trials(5'd16, 5'd8, 5'd12, 5'd10, 5'd9);
        sb_out.push_back({1'b0, 5'd9});
        sb_lat.push_back(5);
        run("restart", -1, 2);
        tick();

        // Asynchronous reset in the 3rd TRY cycle
        target = 5'd21;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst trial",  32'(trial),  32'd0);
        check("async rst result", 32'(result), 32'd0);
        check("async rst busy",   32'(busy),   32'd0);
        check("async rst done",   32'(done),   32'd0);
        check("async rst err",    32'(err),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First search after reset
        target = 5'd7;
        push_trials(5'd16, 5'd8, 5'd4, 5'd6, 5'd7);
        sb_out.push_back({1'b0, 5'd7});
        sb_lat.push_back(5);
        run("t7 post reset", -1, -1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
